// File: rtl/skolem_chk_pkg.sv
// Shared types and the invertibility predicate for Skolem witness checking.
// P(x,s,t) = ((x << s) mod 2^w) >u t, evaluated on a fixed-width carrier.
package skolem_chk_pkg;

  localparam int PW = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    SEARCH,
    CLASSIFY,
    NEXT,
    DONE
  } state_t;

  // Operands are zero-extended to PW bits; w selects the modulus.
  function automatic logic ic_pred(input logic [PW-1:0] x,
                                   input logic [PW-1:0] s,
                                   input logic [PW-1:0] t,
                                   input int            w);
    logic [PW-1:0] mask;
    logic [PW-1:0] sh;
    mask = (w >= PW) ? {PW{1'b1}} : ((PW'(1) << w) - PW'(1));
    sh   = (x << s) & mask;
    return sh > (t & mask);
  endfunction

endpackage

// File: rtl/skolem_witness_checker_if.sv
// Control, stimulus, witness and result bundle between the checker and its host.
// master = checker side, slave = host/Skolem side.
interface skolem_witness_checker_if #(
  parameter int W  = 4,
  parameter int CW = 2*W+1
);
  logic          start;
  logic          busy;
  logic          done;
  logic [W-1:0]  s_o;
  logic [W-1:0]  t_o;
  logic [W-1:0]  x_i;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] vac_cnt;
  logic          ff_valid;
  logic [W-1:0]  ff_s;
  logic [W-1:0]  ff_t;
  logic [W-1:0]  ff_x;

  modport master (
    input  start, x_i,
    output busy, done, s_o, t_o, pass_cnt, fail_cnt, vac_cnt,
           ff_valid, ff_s, ff_t, ff_x
  );

  modport slave (
    output start, x_i,
    input  busy, done, s_o, t_o, pass_cnt, fail_cnt, vac_cnt,
           ff_valid, ff_s, ff_t, ff_x
  );
endinterface

// File: rtl/skolem_ic_search.sv
// Linear search for any x satisfying ic_pred(x,s,t); one candidate per cycle after go.
// found pulses on the first hit (ic=1) or after the last candidate misses (ic=0).
module skolem_ic_search
  import skolem_chk_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         found,
  output logic         ic
);

  logic         active;
  logic [W-1:0] xs;
  logic         hit;

  assign hit   = ic_pred(PW'(xs), PW'(s), PW'(t), W);
  assign found = active & (hit | (&xs));
  assign ic    = hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      xs     <= '0;
    end else if (go) begin
      active <= 1'b1;
      xs     <= '0;
    end else if (active) begin
      if (found) active <= 1'b0;
      else       xs     <= xs + W'(1);
    end
  end

endmodule

// File: rtl/skolem_witness_checker.sv
// Sweeps every (s,t), samples the Skolem witness LAT+1 cycles after the DRIVE window opens,
// and classifies each pair as pass / fail / vacuous against an exhaustive IC search.
module skolem_witness_checker
  import skolem_chk_pkg::*;
#(
  parameter int W   = 4,
  parameter int LAT = 0,
  parameter int CW  = 2*W+1
) (
  input  logic clk,
  input  logic rst,
  skolem_witness_checker_if.master bus
);

  localparam int LW = (LAT > 0) ? $clog2(LAT+1) : 1;
  localparam logic [2*W-1:0] IDX_ONE = 1;

  state_t          state, nxt;
  logic [2*W-1:0]  idx;
  logic [LW-1:0]   wcnt;
  logic [W-1:0]    xw;
  logic            ic_r;
  logic [CW-1:0]   pass_cnt, fail_cnt, vac_cnt;
  logic            ff_valid;
  logic [W-1:0]    ff_s, ff_t, ff_x;
  logic            search_go, search_found, search_ic;
  logic [W-1:0]    s_cur, t_cur;
  logic            idx_last, wait_last, witness_ok;

  assign s_cur      = idx[2*W-1:W];
  assign t_cur      = idx[W-1:0];
  assign idx_last   = &idx;
  assign wait_last  = (wcnt == LW'(LAT));
  assign witness_ok = ic_pred(PW'(xw), PW'(s_cur), PW'(t_cur), W);

  skolem_ic_search #(.W(W)) u_search (
    .clk   (clk),
    .rst   (rst),
    .go    (search_go),
    .s     (s_cur),
    .t     (t_cur),
    .found (search_found),
    .ic    (search_ic)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    search_go = 1'b0;
    unique case (state)
      IDLE:     if (bus.start) nxt = DRIVE;
      DRIVE:    if (wait_last) nxt = SAMPLE;
      SAMPLE: begin
        search_go = 1'b1;
        nxt       = SEARCH;
      end
      SEARCH:   if (search_found) nxt = CLASSIFY;
      CLASSIFY: nxt = NEXT;
      NEXT:     nxt = idx_last ? DONE : DRIVE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // idx doubles as the s_o/t_o register: it only moves on the way into DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      wcnt     <= '0;
      xw       <= '0;
      ic_r     <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      vac_cnt  <= '0;
      ff_valid <= 1'b0;
      ff_s     <= '0;
      ff_t     <= '0;
      ff_x     <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          idx      <= '0;
          wcnt     <= '0;
          pass_cnt <= '0;
          fail_cnt <= '0;
          vac_cnt  <= '0;
          ff_valid <= 1'b0;
          ff_s     <= '0;
          ff_t     <= '0;
          ff_x     <= '0;
        end
        DRIVE:  wcnt <= wait_last ? '0 : wcnt + LW'(1);
        SAMPLE: xw <= bus.x_i;
        SEARCH: if (search_found) ic_r <= search_ic;
        CLASSIFY: begin
          if (!ic_r) begin
            if (vac_cnt != {CW{1'b1}}) vac_cnt <= vac_cnt + CW'(1);
          end else if (witness_ok) begin
            if (pass_cnt != {CW{1'b1}}) pass_cnt <= pass_cnt + CW'(1);
          end else begin
            if (fail_cnt != {CW{1'b1}}) fail_cnt <= fail_cnt + CW'(1);
            if (!ff_valid) begin
              ff_valid <= 1'b1;
              ff_s     <= s_cur;
              ff_t     <= t_cur;
              ff_x     <= xw;
            end
          end
        end
        NEXT: if (!idx_last) idx <= idx + IDX_ONE;
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);
  assign bus.s_o      = s_cur;
  assign bus.t_o      = t_cur;
  assign bus.pass_cnt = pass_cnt;
  assign bus.fail_cnt = fail_cnt;
  assign bus.vac_cnt  = vac_cnt;
  assign bus.ff_valid = ff_valid;
  assign bus.ff_s     = ff_s;
  assign bus.ff_t     = ff_t;
  assign bus.ff_x     = ff_x;

endmodule
